// File: rtl/mux8_serializer_if.sv
// Bus bundle between the word serializer, its upstream word source,
// the 8:1 bit mux it feeds, and the downstream serial sink.
interface mux8_serializer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] word_reg;
  logic [2:0] sel;
  logic       mux_out;
  logic       ser_data;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_last;

  // Serializer side: owns the ready/valid it produces and the mux controls.
  modport master (
    input  in_data, in_valid, mux_out, ser_ready,
    output in_ready, word_reg, sel, ser_data, ser_valid, ser_last
  );

  // Environment side: word source, mux and serial sink.
  modport slave (
    output in_data, in_valid, mux_out, ser_ready,
    input  in_ready, word_reg, sel, ser_data, ser_valid, ser_last
  );
endinterface

// File: rtl/mux8_serializer.sv
// Word-to-bit sequencer: registers an accepted byte onto the 8:1 mux data
// inputs, walks the mux select once per accepted beat, returns the stream.
module mux8_serializer #(
  parameter bit          MSB_FIRST  = 1'b0,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  mux8_serializer_if.master  bus,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [2:0] START_SEL_C = MSB_FIRST ? 3'd7 : 3'd0;
  localparam bit         GAP_ZERO_C  = (GAP_CYCLES == 32'd0);
  localparam logic [3:0] GAP_LOAD_C  = GAP_ZERO_C ? 4'd0 : 4'(GAP_CYCLES - 32'd1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] word_r;
  logic [2:0] sel_r;
  logic [2:0] bit_cnt_r;
  logic [3:0] gap_cnt_r;

  logic beat_s;
  logic last_beat_s;
  logic load_s;
  logic in_ready_s;
  logic ser_valid_s;
  logic busy_s;

  assign beat_s      = (state_r == SHIFT) && bus.ser_ready;
  assign last_beat_s = beat_s && (bit_cnt_r == 3'd7);
  assign load_s      = bus.in_valid && in_ready_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_s) state_nxt_s = SHIFT;
        else        state_nxt_s = IDLE;
      end
      SHIFT: begin
        if (!last_beat_s)    state_nxt_s = SHIFT;
        else if (!GAP_ZERO_C) state_nxt_s = GAP;
        else if (load_s)     state_nxt_s = SHIFT;
        else                 state_nxt_s = IDLE;
      end
      GAP: begin
        if (gap_cnt_r == 4'd0) state_nxt_s = IDLE;
        else                   state_nxt_s = GAP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode; in_ready follows ser_ready on a gapless final beat so
  // consecutive words stream without a bubble.
  always_comb begin
    in_ready_s  = 1'b0;
    ser_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = rst_n;
      end
      SHIFT: begin
        ser_valid_s = 1'b1;
        busy_s      = 1'b1;
        if (last_beat_s && GAP_ZERO_C) in_ready_s = 1'b1;
        else                           in_ready_s = 1'b0;
      end
      GAP: begin
        busy_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Word, select and counters; the 3-bit select wraps naturally after beat 8.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r    <= 8'h00;
      sel_r     <= 3'd0;
      bit_cnt_r <= 3'd0;
      gap_cnt_r <= 4'd0;
    end else if (load_s) begin
      word_r    <= bus.in_data;
      sel_r     <= START_SEL_C;
      bit_cnt_r <= 3'd0;
    end else if (beat_s) begin
      bit_cnt_r <= bit_cnt_r + 3'd1;
      sel_r     <= MSB_FIRST ? (sel_r - 3'd1) : (sel_r + 3'd1);
      if (last_beat_s) gap_cnt_r <= GAP_LOAD_C;
    end else if ((state_r == GAP) && (gap_cnt_r != 4'd0)) begin
      gap_cnt_r <= gap_cnt_r - 4'd1;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.word_reg  = word_r;
  assign bus.sel       = sel_r;
  assign bus.ser_valid = ser_valid_s;
  assign bus.ser_data  = bus.mux_out & ser_valid_s;
  assign bus.ser_last  = ser_valid_s && (bit_cnt_r == 3'd7);
  assign busy          = busy_s;

endmodule
